// File: rtl/instr_encoder.sv
// RV32I instruction encoder.
// Accepts a bundle of instruction fields, packs them into a 32-bit RV32I word
// according to the requested format, and queues the result in a 2-entry
// in-order FIFO with a valid/ready handshake on both sides. Each queued entry
// carries an illegal flag: it is set for unknown kinds, which are replaced by
// a NOP, and for branch/JAL offsets that are not 2-byte aligned. A 16-bit
// counter tracks completed output handshakes.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_illegal,
    output logic [15:0] instr_count
);

    // Request kinds
    localparam logic [2:0] KIND_LOAD   = 3'd0;
    localparam logic [2:0] KIND_STORE  = 3'd1;
    localparam logic [2:0] KIND_RTYPE  = 3'd2;
    localparam logic [2:0] KIND_BRANCH = 3'd3;
    localparam logic [2:0] KIND_IALU   = 3'd4;
    localparam logic [2:0] KIND_JAL    = 3'd5;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // I-type: imm[11:0] | rs1 | funct3 | rd | opcode
    function automatic logic [31:0] enc_i_type(input logic [31:0] imm,
                                               input logic [4:0]  rs1,
                                               input logic [2:0]  f3,
                                               input logic [4:0]  rd,
                                               input logic [6:0]  opcode);
        return {imm[11:0], rs1, f3, rd, opcode};
    endfunction

    // S-type: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
    function automatic logic [31:0] enc_s_type(input logic [31:0] imm,
                                               input logic [4:0]  rs2,
                                               input logic [4:0]  rs1,
                                               input logic [2:0]  f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    // R-type: funct7 | rs2 | rs1 | funct3 | rd | opcode
    function automatic logic [31:0] enc_r_type(input logic [6:0] f7,
                                               input logic [4:0] rs2,
                                               input logic [4:0] rs1,
                                               input logic [2:0] f3,
                                               input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_RTYPE};
    endfunction

    // B-type: the scrambled 13-bit offset; bit 0 is implicit zero
    function automatic logic [31:0] enc_b_type(input logic [31:0] imm,
                                               input logic [4:0]  rs2,
                                               input logic [4:0]  rs1,
                                               input logic [2:0]  f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    // J-type: the scrambled 21-bit offset; bit 0 is implicit zero
    function automatic logic [31:0] enc_j_type(input logic [31:0] imm,
                                               input logic [4:0]  rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    // Upper immediate bits are never part of any format; they are dropped on purpose.
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:21];

    // Encoder output for the current request
    logic [31:0] enc_instr;
    logic        enc_illegal;

    // FIFO storage (data only, not reset) and control state
    logic [31:0] instr_q [2];
    logic [1:0]  illegal_q;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic push;
    logic pop;

    // Select the instruction format from the request kind and flag bad requests
    always_comb begin
        enc_instr   = NOP_INSTR;
        enc_illegal = 1'b0;
        case (in_kind)
            KIND_LOAD:   enc_instr = enc_i_type(in_imm, in_rs1, in_funct3, in_rd, OP_LOAD);
            KIND_STORE:  enc_instr = enc_s_type(in_imm, in_rs2, in_rs1, in_funct3);
            KIND_RTYPE:  enc_instr = enc_r_type(in_funct7, in_rs2, in_rs1, in_funct3, in_rd);
            KIND_BRANCH: begin
                enc_instr   = enc_b_type(in_imm, in_rs2, in_rs1, in_funct3);
                enc_illegal = in_imm[0];
            end
            KIND_IALU:   enc_instr = enc_i_type(in_imm, in_rs1, in_funct3, in_rd, OP_IALU);
            KIND_JAL: begin
                enc_instr   = enc_j_type(in_imm, in_rd);
                enc_illegal = in_imm[0];
            end
            default: begin
                enc_instr   = NOP_INSTR;
                enc_illegal = 1'b1;
            end
        endcase
    end

    // Handshakes: in_ready depends only on stored occupancy, so a same-cycle
    // pop never opens a slot in a full FIFO.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head entry is masked to zero whenever the FIFO is empty
    assign out_instr   = out_valid ? instr_q[rd_ptr_q]   : 32'h0;
    assign out_illegal = out_valid ? illegal_q[rd_ptr_q] : 1'b0;
    assign instr_count = instr_count_q;

    // Next-state for pointers, occupancy and the handshake counter
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        instr_count_d = instr_count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d      = ~rd_ptr_q;
            instr_count_d = instr_count_q + 16'd1;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Control registers; reset empties the FIFO and clears the counter at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            instr_count_q <= 16'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instr_count_q <= instr_count_d;
        end
    end

    // FIFO storage write; contents are only visible through the occupancy mask
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q]   <= enc_instr;
            illegal_q[wr_ptr_q] <= enc_illegal;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO handshakes, counter wrap, reset.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_illegal;
    logic [15:0] instr_count;

    int          checks;
    int          failures;
    logic [15:0] exp_cnt;
    logic [31:0] exp_word;

    instr_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_illegal(out_illegal),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_kind   = kind;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    // One request into an empty FIFO: check latency-1 word and flag, then drain it.
    task automatic one_shot(input string tag, input logic [2:0] kind, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] exp_instr, input logic exp_ill);
        drive(kind, rd, rs1, rs2, f3, f7, imm);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_instr"}, out_instr, exp_instr);
        chk({tag, "_illegal"}, out_illegal, exp_ill);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_drained"}, out_valid, 0);
        chk({tag, "_count"}, instr_count, exp_cnt);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_cnt   = 16'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_instr_count", instr_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);

        // R-type on first edge after release; not visible before the edge
        drive(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        #1;
        chk("rtype_not_early", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("rtype_valid", out_valid, 1);
        chk("rtype_instr", out_instr, 32'h002081B3);
        chk("rtype_illegal", out_illegal, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        chk("rtype_count", instr_count, exp_cnt);
        chk("rtype_empty_instr", out_instr, 0);

        // Formats and illegal flags
        one_shot("store",   3'd1, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8,        32'h00512423, 1'b0);
        one_shot("branch",  3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        one_shot("jal",     3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
        one_shot("jal_odd", 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000801, 32'h001000EF, 1'b1);
        one_shot("kind7",   3'd7, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'h12345678, 32'h00000013, 1'b1);
        one_shot("kind6",   3'd6, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd0,        32'h00000013, 1'b1);
        one_shot("load_hi", 3'd0, 5'd5, 5'd6, 5'd31, 3'd2, 7'h7F, 32'hFFFFF123, 32'h12332283, 1'b0);
        one_shot("ialu",    3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000FFF, 32'hFFF00093, 1'b0);
        one_shot("br_odd",  3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000005, 32'h00000263, 1'b1);

        // Backpressure: three requests, two accepted, third held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        chk("bp_ready_after_1", in_ready, 1);
        drive(3'd2, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        chk("bp_ready_after_2", in_ready, 0);
        drive(3'd2, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        chk("bp_hold_head", out_instr, 32'h000000B3);
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_pop_full_ready", in_ready, 1);
        chk("bp_second", out_instr, 32'h00000133);
        tick();
        exp_cnt++;
        in_valid = 1'b0;
        chk("bp_third", out_instr, 32'h000001B3);
        chk("bp_third_valid", out_valid, 1);
        tick();
        exp_cnt++;
        out_ready = 1'b0;
        chk("bp_empty", out_valid, 0);
        chk("bp_count", instr_count, exp_cnt);

        // Streaming: one word per cycle, newest entry always at the head
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3'd4, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1));
            exp_word = {12'(i + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13};
            tick();
            if (i > 0) exp_cnt++;
            chk("stream_instr", out_instr, exp_word);
            chk("stream_ready", in_ready, 1);
        end
        drive(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        for (int n = 0; n < 70000 && exp_cnt != 16'hFFFF; n++) begin
            tick();
            exp_cnt++;
        end
        chk("wrap_preload", instr_count, 16'hFFFF);
        chk("wrap_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("wrap_zero", instr_count, 16'h0000);
        chk("wrap_empty", out_valid, 0);
        out_ready = 1'b0;

        // Reset mid-operation with two entries buffered
        in_valid = 1'b1;
        drive(3'd2, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        tick();
        chk("mid_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", instr_count, 0);
        chk("mid_rst_instr", out_instr, 0);
        tick();
        chk("mid_rst_ignore_in", out_valid, 0);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("mid_release_ready", in_ready, 1);
        chk("mid_release_valid", out_valid, 0);
        in_valid = 1'b1;
        drive(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("mid_after_instr", out_instr, 32'h002081B3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
